// File: rtl/aes_frame_assembler.sv
// Assembles header-tagged UART byte frames into NUM_BYTES-wide words for the AES core.
// Define AES_FRAME_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module aes_frame_assembler #(
    parameter int          NUM_BYTES      = 16,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  HDR_KEY        = 8'hA5,
    parameter logic [7:0]  HDR_PT         = 8'h5A
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic [NUM_BYTES*8-1:0] data_out,
    output logic                   data_is_key,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic                   frame_error,
    output logic                   overrun
);
    localparam int W  = NUM_BYTES * 8;
    localparam int BW = $clog2(NUM_BYTES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

`ifdef AES_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, CHECK = 2'd2, DELIVER = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DELIVER = 2'd3} state_t;
`endif

    state_t          state, state_next;
    logic [BW-1:0]   byte_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            start, shift_en, tmo_inc, err_next, ovr_next;
`ifdef AES_FRAME_CHECKSUM_EN
    logic [7:0]      xor_acc;
`endif

    always_comb begin
        state_next = state;
        start      = 1'b0;
        shift_en   = 1'b0;
        tmo_inc    = 1'b0;
        err_next   = 1'b0;
        ovr_next   = 1'b0;
        case (state)
            IDLE: begin
                if (byte_valid && (byte_in == HDR_KEY || byte_in == HDR_PT)) begin
                    state_next = COLLECT;
                    start      = 1'b1;
                end
            end
            COLLECT: begin
                if (byte_valid) begin
                    shift_en = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
`ifdef AES_FRAME_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = DELIVER;
`endif
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
`ifdef AES_FRAME_CHECKSUM_EN
            CHECK: begin
                if (byte_valid) begin
                    if (byte_in == xor_acc) begin
                        state_next = DELIVER;
                    end else begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
`endif
            DELIVER: begin
                // Bytes arriving here have nowhere to go; including the handshake cycle.
                ovr_next = byte_valid;
                if (data_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign data_valid = (state == DELIVER);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            data_out    <= '0;
            data_is_key <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
`ifdef AES_FRAME_CHECKSUM_EN
            xor_acc     <= '0;
`endif
        end else begin
            state       <= state_next;
            frame_error <= err_next;
            overrun     <= ovr_next;
            if (start) begin
                data_is_key <= (byte_in == HDR_KEY);
                byte_cnt    <= '0;
                tmo_cnt     <= '0;
`ifdef AES_FRAME_CHECKSUM_EN
                xor_acc     <= '0;
`endif
            end
            if (shift_en) begin
                data_out <= {data_out[W-9:0], byte_in};
                byte_cnt <= byte_cnt + BW'(1);
                tmo_cnt  <= '0;
`ifdef AES_FRAME_CHECKSUM_EN
                xor_acc  <= xor_acc ^ byte_in;
`endif
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_aes_frame_assembler.sv
// Scoreboard bench for aes_frame_assembler; a second instance with a short timeout
// covers the inter-byte timeout path.
module tb_aes_frame_assembler;
    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   byte_in;
    logic         byte_valid, to_valid, data_ready, to_ready;
    logic [127:0] data_out, to_data;
    logic         data_is_key, data_valid, frame_error, overrun;
    logic         to_key, to_dv, to_fe, to_ov;

    always #5 clk = ~clk;

    aes_frame_assembler dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .data_out(data_out), .data_is_key(data_is_key), .data_valid(data_valid),
        .data_ready(data_ready), .frame_error(frame_error), .overrun(overrun)
    );

    aes_frame_assembler #(.TIMEOUT_CYCLES(64)) dut_to (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(to_valid),
        .data_out(to_data), .data_is_key(to_key), .data_valid(to_dv),
        .data_ready(to_ready), .frame_error(to_fe), .overrun(to_ov)
    );

    typedef struct packed {
        logic         key;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0, n_err = 0;
    int   dv_cycles = 0, fe_cnt = 0, ov_cnt = 0, to_fe_cnt = 0;

    // Output monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid) dv_cycles++;
            if (frame_error) fe_cnt++;
            if (overrun) ov_cnt++;
            if (to_fe) to_fe_cnt++;
            if (data_valid && data_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got key=%0b data=%h, expected no word", data_is_key, data_out);
                end else begin
                    mon_e = sb.pop_front();
                    if ({data_is_key, data_out} !== {mon_e.key, mon_e.data}) begin
                        n_err++;
                        $display("FAIL sb_word: got key=%0b data=%h, expected key=%0b data=%h",
                                 data_is_key, data_out, mon_e.key, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit to);
        @(posedge clk); #1;
        byte_in = b;
        if (to) to_valid = 1'b1; else byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        to_valid   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [127:0] p, input int gap, input bit to);
        logic [7:0] x;
        x = 8'h00;
        send_byte(hdr, to);
        for (int i = 0; i < 16; i++) begin
            repeat (gap) @(posedge clk);
            send_byte(p[127-8*i -: 8], to);
            x = x ^ p[127-8*i -: 8];
        end
`ifdef AES_FRAME_CHECKSUM_EN
        repeat (gap) @(posedge clk);
        send_byte(x, to);
`endif
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d words still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; byte_valid = 1'b0; to_valid = 1'b0; byte_in = 8'h00;
        data_ready = 1'b0; to_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, expected 0", data_valid); end
        n_cmp++; if (data_out !== 128'h0) begin n_err++; $display("FAIL rst_data: got %h, expected 0", data_out); end
        n_cmp++; if (data_is_key !== 1'b0) begin n_err++; $display("FAIL rst_key: got %b, expected 0", data_is_key); end
        n_cmp++; if (frame_error !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b, expected 0", frame_error); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_ovr: got %b, expected 0", overrun); end
        reset = 1'b0;
        // Reset in the middle of a frame must discard it silently.
        fe_cnt = 0; dv_cycles = 0;
        send_byte(8'hA5, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h11 * i, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk); #1;
        n_cmp++; if (fe_cnt !== 0) begin n_err++; $display("FAIL rst_midframe_err: got %0d pulses, expected 0", fe_cnt); end
        n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_midframe_valid: got %b, expected 0", data_valid); end
    endtask

    task automatic test_key_frame;
        logic [127:0] p;
        p = 128'h000102030405060708090A0B0C0D0E0F;
        data_ready = 1'b1; dv_cycles = 0; fe_cnt = 0;
        sb.push_back({1'b1, p});
        send_frame(8'hA5, p, 100, 0);
        n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL key_latency: data_valid got %b, expected 1", data_valid); end
        wait_drain(10);
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (dv_cycles !== 1) begin n_err++; $display("FAIL key_valid_cycles: got %0d, expected 1", dv_cycles); end
        n_cmp++; if (fe_cnt !== 0) begin n_err++; $display("FAIL key_err: got %0d pulses, expected 0", fe_cnt); end
    endtask

    task automatic test_backpressure;
        int hold_bad;
        data_ready = 1'b0; dv_cycles = 0; hold_bad = 0;
        sb.push_back({1'b0, {128{1'b1}}});
        send_frame(8'h5A, {128{1'b1}}, 0, 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (data_valid !== 1'b1 || data_out !== {128{1'b1}} || data_is_key !== 1'b0) hold_bad++;
        end
        n_cmp++; if (hold_bad !== 0) begin n_err++; $display("FAIL bp_hold: %0d unstable cycles, expected 0", hold_bad); end
        @(posedge clk); #1;
        data_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle: data_valid got %b, expected 0", data_valid); end
        wait_drain(5);
        n_cmp++; if (dv_cycles < 51) begin n_err++; $display("FAIL bp_cycles: got %0d, expected >= 51", dv_cycles); end
    endtask

    task automatic test_ignore;
        logic [127:0] p;
        data_ready = 1'b1;
        p = {$urandom, $urandom, $urandom, $urandom};
        p[127 -: 8] = 8'hA5;
        p[71 -: 8]  = 8'h5A;
        sb.push_back({1'b0, p});
        send_byte(8'h33, 0);
        send_frame(8'h5A, p, 2, 0);
        wait_drain(10);
    endtask

    task automatic test_overrun;
        logic [127:0] p;
        data_ready = 1'b0; ov_cnt = 0;
        p = {$urandom, $urandom, $urandom, $urandom};
        sb.push_back({1'b1, p});
        send_frame(8'hA5, p, 0, 0);
        send_byte(8'hC3, 0);
        repeat (2) @(posedge clk);
        send_byte(8'h3C, 0);
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (ov_cnt !== 2) begin n_err++; $display("FAIL ovr_count: got %0d, expected 2", ov_cnt); end
        n_cmp++; if (data_out !== p) begin n_err++; $display("FAIL ovr_data: got %h, expected %h", data_out, p); end
        data_ready = 1'b1;
        wait_drain(5);
    endtask

    task automatic test_timeout;
        logic [127:0] p;
        int first_k;
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        to_fe_cnt = 0; first_k = -1;
        send_byte(8'hA5, 1);
        for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i), 1);
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (to_fe && first_k < 0) first_k = k;
        end
        n_cmp++; if (to_fe_cnt !== 1) begin n_err++; $display("FAIL tmo_count: got %0d pulses, expected 1", to_fe_cnt); end
        n_cmp++; if (first_k < 64 || first_k > 65) begin n_err++; $display("FAIL tmo_time: pulse at +%0d cycles, expected +64..65", first_k); end
        p = {$urandom, $urandom, $urandom, $urandom};
        send_frame(8'h5A, p, 3, 1);
        n_cmp++; if (to_dv !== 1'b1) begin n_err++; $display("FAIL tmo_next_valid: got %b, expected 1", to_dv); end
        n_cmp++; if (to_data !== p) begin n_err++; $display("FAIL tmo_next_data: got %h, expected %h", to_data, p); end
        n_cmp++; if (to_key !== 1'b0) begin n_err++; $display("FAIL tmo_next_key: got %b, expected 0", to_key); end
        repeat (3) @(posedge clk); #1;
    endtask

`ifdef AES_FRAME_CHECKSUM_EN
    task automatic test_checksum;
        logic [127:0] p;
        p = 128'h0102030405060708090A0B0C0D0E0F10;
        data_ready = 1'b1;
        sb.push_back({1'b1, p});
        send_byte(8'hA5, 0);
        for (int i = 0; i < 16; i++) send_byte(p[127-8*i -: 8], 0);
        send_byte(8'h10, 0);
        wait_drain(10);
        dv_cycles = 0; fe_cnt = 0;
        send_byte(8'hA5, 0);
        for (int i = 0; i < 16; i++) send_byte(p[127-8*i -: 8], 0);
        send_byte(8'h11, 0);
        repeat (5) @(posedge clk); #1;
        n_cmp++; if (fe_cnt !== 1) begin n_err++; $display("FAIL csum_err: got %0d pulses, expected 1", fe_cnt); end
        n_cmp++; if (dv_cycles !== 0) begin n_err++; $display("FAIL csum_valid: got %0d cycles, expected 0", dv_cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_key_frame();
        test_backpressure();
        test_ignore();
        test_overrun();
        test_timeout();
`ifdef AES_FRAME_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
